// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - time-division demultiplexer with sync-based frame alignment
module tdm_demux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2,
    parameter int SW       = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      sync,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] y,
    output logic                      frame_valid,
    output logic [SW-1:0]             slot,
    output logic                      locked,
    output logic                      sync_err
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] ONE       = SW'(1);

    state_t                          state_q, state_d;
    logic [SW-1:0]                   slot_q, slot_d;
    logic [(CHANNELS-1)*WIDTH-1:0]   shadow_q, shadow_d;
    logic [CHANNELS*WIDTH-1:0]       y_q, y_d;
    logic                            fv_q, fv_d;
    logic                            err_q, err_d;
    logic                            err_evt;

    // State, shadow and output registers; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            y_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    // Next-state: only valid samples advance; error set beats err_clr
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        fv_d     = 1'b0;
        err_evt  = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[WIDTH-1:0] = din;
                        slot_d              = ONE;
                        state_d             = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync anywhere but slot 0 restarts the frame at this sample
                        if (slot_q != '0) begin
                            err_evt = 1'b1;
                        end
                        shadow_d[WIDTH-1:0] = din;
                        slot_d              = ONE;
                    end else if (slot_q == '0) begin
                        err_evt = 1'b1;
                        state_d = HUNT;
                    end else if (slot_q == LAST_SLOT) begin
                        y_d    = {din, shadow_q};
                        fv_d   = 1'b1;
                        slot_d = '0;
                    end else begin
                        for (int c = 1; c < CHANNELS - 1; c++) begin
                            if (slot_q == SW'(c)) begin
                                shadow_d[c*WIDTH +: WIDTH] = din;
                            end
                        end
                        slot_d = slot_q + ONE;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
        if (err_evt) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign y           = y_q;
    assign frame_valid = fv_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux with randomized frames
module tb_tdm_demux;

    localparam int W  = 4;
    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          sync = 1'b0;
    logic          err_clr = 1'b0;
    logic [CH*W-1:0] y;
    logic          frame_valid;
    logic [1:0]    slot;
    logic          locked;
    logic          sync_err;

    logic          din2 = 1'b0;
    logic          valid2 = 1'b0;
    logic          sync2 = 1'b0;
    logic [1:0]    y2;
    logic          fv2;
    logic [0:0]    slot2;
    logic          locked2;
    logic          err2;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [W-1:0]    fq[$];
    logic [CH*W-1:0] exp_q[$];
    bit              m_locked = 0;
    bit              m_err = 0;
    bit              m_fv = 0;
    logic [CH*W-1:0] m_y = '0;
    int              frames_exp = 0;
    int              frames_seen = 0;

    tdm_demux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .err_clr(err_clr), .y(y), .frame_valid(frame_valid), .slot(slot),
        .locked(locked), .sync_err(sync_err)
    );

    tdm_demux #(.WIDTH(1), .CHANNELS(2)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(valid2), .sync(sync2),
        .err_clr(1'b0), .y(y2), .frame_valid(fv2), .slot(slot2),
        .locked(locked2), .sync_err(err2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        fq.delete();
        m_locked = 0;
        m_err    = 0;
        m_fv     = 0;
        m_y      = '0;
    endtask

    // Frame assembly described by collected slot list length, not a slot counter
    task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit c);
        bit evt;
        logic [CH*W-1:0] w;
        evt  = 0;
        m_fv = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1;
                    fq = {d};
                end
            end else if (s) begin
                if (fq.size() != 0) evt = 1;
                fq = {d};
            end else if (fq.size() == 0) begin
                evt = 1;
                m_locked = 0;
            end else begin
                fq.push_back(d);
                if (fq.size() == CH) begin
                    w = '0;
                    for (int i = 0; i < CH; i++) w[i*W +: W] = fq[i];
                    m_y  = w;
                    m_fv = 1;
                    exp_q.push_back(w);
                    frames_exp++;
                    fq.delete();
                end
            end
        end
        if (evt) m_err = 1;
        else if (c) m_err = 0;
    endtask

    task automatic cycle(input bit v, input bit s, input logic [W-1:0] d, input bit c = 0);
        din_valid = v;
        sync      = s;
        din       = d;
        err_clr   = c;
        @(posedge clk);
        model_step(v, s, d, c);
        #1;
        chk("slot", slot, fq.size());
        chk("locked", locked, m_locked);
        chk("sync_err", sync_err, m_err);
        chk("y_hold", y, m_y);
        chk("frame_valid", frame_valid, m_fv);
        din_valid = 0;
        sync      = 0;
        err_clr   = 0;
    endtask

    // Scoreboard monitor: every frame_valid pulse must match a queued frame
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            frames_seen++;
            if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
            else chk("frame_y", y, exp_q.pop_front());
        end
    end

    initial begin
        bit s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_slot", slot, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", sync_err, 0);
        rst = 1'b0;

        // hunt drops unsynced samples
        cycle(1, 0, 4'h5);
        cycle(1, 0, 4'h6);
        chk("hunt_locked", locked, 0);
        chk("hunt_y", y, 0);

        // normal frame
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h2);
        cycle(1, 0, 4'h3);
        chk("normal_y", y, 12'h321);
        chk("normal_fv", frame_valid, 1);
        cycle(0, 0, 4'h0);
        chk("normal_fv_drop", frame_valid, 0);

        // gapped input
        cycle(1, 1, 4'h1);
        cycle(0, 0, 4'hF);
        cycle(0, 1, 4'hE);
        cycle(1, 0, 4'h2);
        cycle(0, 0, 4'h0);
        cycle(1, 0, 4'h3);
        chk("gap_y", y, 12'h321);

        // back-to-back frames
        cycle(1, 1, 4'h4);
        cycle(1, 0, 4'h5);
        cycle(1, 0, 4'h6);
        chk("b2b_y0", y, 12'h654);
        cycle(1, 1, 4'h7);
        cycle(1, 0, 4'h8);
        cycle(1, 0, 4'h9);
        chk("b2b_y1", y, 12'h987);
        chk("b2b_fv", frame_valid, 1);

        // early sync
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h2);
        cycle(1, 1, 4'hA);
        chk("early_err", sync_err, 1);
        cycle(1, 0, 4'hB);
        cycle(1, 0, 4'hC);
        chk("early_y", y, 12'hCBA);
        cycle(0, 0, 4'h0, 1);
        chk("err_clr", sync_err, 0);

        // missing sync
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h2);
        cycle(1, 0, 4'h3);
        cycle(1, 0, 4'hD);
        chk("miss_err", sync_err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_y", y, 12'h321);
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h2);
        cycle(1, 0, 4'h3);
        chk("relock", locked, 1);
        cycle(0, 0, 4'h0, 1);

        // err_clr with simultaneous early sync
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h2);
        cycle(1, 1, 4'h4, 1);
        chk("set_beats_clr", sync_err, 1);

        // asynchronous reset mid-frame
        cycle(1, 0, 4'h5);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_y", y, 0);
        chk("arst_slot", slot, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", sync_err, 0);
        chk("arst_fv", frame_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // randomized streams
        for (int n = 0; n < 400; n++) begin
            if (fq.size() == 0) s = ($urandom_range(0, 7) != 0);
            else s = ($urandom_range(0, 11) == 0);
            cycle(($urandom_range(0, 3) != 0), s, W'($urandom), ($urandom_range(0, 7) == 0));
        end

        // two-channel, one-bit instance
        valid2 = 1; sync2 = 1; din2 = 1;
        @(posedge clk);
        #1 sync2 = 0; din2 = 0;
        @(posedge clk);
        #1;
        valid2 = 0;
        chk("ch2_y", y2, 2'b01);
        chk("ch2_fv", fv2, 1);
        chk("ch2_locked", locked2, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        chk("frame_count", frames_seen, frames_exp);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
